// File: rtl/pru_cmd_queue.sv
// PRU command front-end: decodes CPU register writes, stages draw parameters,
// queues committed commands and issues them one at a time over start/busy/done.
module pru_cmd_queue #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          DEPTH         = 4,
  parameter int          START_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [31:0]              wr_addr,
  input  logic [31:0]              wr_data,
  output logic [9:0]               row,
  output logic [8:0]               col,
  output logic [9:0]               width,
  output logic [8:0]               height_radius,
  output logic [1:0]               shape_select,
  output logic [1:0]               color,
  output logic                     subtract,
  output logic                     start,
  input  logic                     busy,
  input  logic                     done,
  output logic [$clog2(DEPTH):0]   cmd_count,
  output logic                     cmd_full,
  output logic                     idle,
  output logic                     overflow,
  output logic                     timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(START_TIMEOUT) + 1;
  localparam int EW = 43;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          state;
  logic [TW-1:0]   tmr;
  logic [AW-1:0]   wptr, rptr;
  logic [EW-1:0]   mem [DEPTH];
  logic [9:0]      st_row, st_w;
  logic [8:0]      st_col, st_h;

  logic hit_geom, hit_size, hit_ctrl, hit_clr;
  logic pop, push, flush, clr_flags, tmo_hit;
  logic [EW-1:0] entry_in;
  logic unused_bits;

  assign hit_geom  = wr_en && (wr_addr == BASE_ADDR);
  assign hit_size  = wr_en && (wr_addr == BASE_ADDR + 32'h4);
  assign hit_ctrl  = wr_en && (wr_addr == BASE_ADDR + 32'h8);
  assign hit_clr   = wr_en && (wr_addr == BASE_ADDR + 32'hC);
  assign flush     = hit_clr && wr_data[1];
  assign clr_flags = hit_clr && wr_data[0];

  assign entry_in = {st_row, st_col, st_w, st_h, wr_data[1:0], wr_data[5:4], wr_data[8]};
  assign unused_bits = ^{wr_data[31:25], wr_data[15:10]};

  assign cmd_full = (cmd_count == CW'(DEPTH));
  assign idle     = (cmd_count == '0) && (state == S_IDLE);
  assign pop      = (state == S_IDLE) && (cmd_count != '0);
  // A full queue still takes the commit when the head leaves on the same edge
  assign push     = hit_ctrl && (!cmd_full || pop);
  assign tmo_hit  = (state == S_ISSUE) && !busy && !done && (tmr == TW'(START_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= entry_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      tmr           <= '0;
      wptr          <= '0;
      rptr          <= '0;
      cmd_count     <= '0;
      st_row        <= '0;
      st_col        <= '0;
      st_w          <= '0;
      st_h          <= '0;
      row           <= '0;
      col           <= '0;
      width         <= '0;
      height_radius <= '0;
      shape_select  <= '0;
      color         <= '0;
      subtract      <= 1'b0;
      start         <= 1'b0;
      overflow      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      if (hit_geom) begin
        st_row <= wr_data[9:0];
        st_col <= wr_data[24:16];
      end
      if (hit_size) begin
        st_w <= wr_data[9:0];
        st_h <= wr_data[24:16];
      end
      if (push) wptr <= wptr + AW'(1);
      // Flushing jumps the read pointer to the write pointer; a same-cycle pop has already taken the head
      if (flush)    rptr <= wptr;
      else if (pop) rptr <= rptr + AW'(1);
      cmd_count <= flush ? '0 : cmd_count + CW'(push) - CW'(pop);

      overflow    <= (hit_ctrl && !push) || (overflow && !clr_flags);
      timeout_err <= tmo_hit || (timeout_err && !clr_flags);

      case (state)
        S_IDLE: begin
          if (pop) begin
            {row, col, width, height_radius, shape_select, color, subtract} <= mem[rptr];
            start <= 1'b1;
            tmr   <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (busy) begin
            start <= 1'b0;
            state <= S_WAIT;
          end else if (done || tmo_hit) begin
            start <= 1'b0;
            state <= S_IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_WAIT: begin
          if (done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
